// File: rtl/sdr_peer.sv
// sdr_peer: board-side partner for the CIA serial port, receiving bytes over SP/CNT and sending them back. Optional macro SDR_PEER_RX_TIMEOUT_EN.
// Latency: rx_valid 3 clk after the 8th raw cnt_in rise; a transmitted byte occupies the line for 19*CLK_DIV clk.
// Backpressure: tx_ready is low while transmitting, during a partial receive, or while CNT is not idle high.
module sdr_peer #(
    parameter int CLK_DIV    = 16,
    parameter int RX_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    input  logic       cnt_in,
    input  logic       sp_in,
    output logic       cnt_out,
    output logic       cnt_oe,
    output logic       sp_out
);

    localparam int TMR_W = $clog2(2 * CLK_DIV) + 1;
    localparam logic [TMR_W-1:0] HALF_END = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_END  = TMR_W'(2 * CLK_DIV - 1);

    // A CNT half-period shorter than 8 clk is too fast for a CIA sampling on phi2 = clk/4.
    if (CLK_DIV < 8 || RX_TIMEOUT < 2) begin : g_param_check
        $error("sdr_peer: CLK_DIV must be >= 8 and RX_TIMEOUT >= 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_GAP} state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    // Pin synchronisers; they reset high because the idle line is pulled up.
    logic       r_cnt_m, r_cnt_s, r_cnt_prev;
    logic       r_sp_m, r_sp_s;

    // Receive side. Only 7 bits are kept: the 8th arrives straight from sp_s.
    logic [6:0] r_rx_shift;
    logic [2:0] r_rx_cnt;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;

    // Transmit side.
    logic [7:0]       r_tx_shift;
    logic [2:0]       r_bit;
    logic [TMR_W-1:0] r_tmr;
    logic             r_idle_q;

    logic       w_cnt_rise;
    logic       w_rx_edge;
    logic       w_rx_timeout;
    logic       w_accept;
    logic       w_tmr_done;
    logic       w_cnt_oe, w_cnt_out, w_sp_out;

    assign w_cnt_rise = r_cnt_s & ~r_cnt_prev;
    // Our own CNT toggles loop back through the pin; they must not be taken as received bits.
    assign w_rx_edge  = w_cnt_rise & ~w_cnt_oe;

    // r_idle_q delays tx_ready one cycle after returning to IDLE and keeps it low through reset.
    assign tx_ready = (r_state == S_IDLE) && r_idle_q && (r_rx_cnt == 3'd0) && r_cnt_s;
    assign w_accept = tx_valid && tx_ready;

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = (r_state != S_IDLE) || (r_rx_cnt != 3'd0);
    assign cnt_oe   = w_cnt_oe;
    assign cnt_out  = w_cnt_out;
    assign sp_out   = w_sp_out;

    // Double-flop the CNT and SP pins and keep the previous CNT level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_m    <= 1'b1;
            r_cnt_s    <= 1'b1;
            r_cnt_prev <= 1'b1;
            r_sp_m     <= 1'b1;
            r_sp_s     <= 1'b1;
        end else begin
            r_cnt_m    <= cnt_in;
            r_cnt_s    <= r_cnt_m;
            r_cnt_prev <= r_cnt_s;
            r_sp_m     <= sp_in;
            r_sp_s     <= r_sp_m;
        end
    end

`ifdef SDR_PEER_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(RX_TIMEOUT) + 1;
    localparam logic [TO_W-1:0] TO_END = TO_W'(RX_TIMEOUT - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_cnt_edge;

    assign w_cnt_edge   = r_cnt_s ^ r_cnt_prev;
    assign w_rx_timeout = (r_rx_cnt != 3'd0) && (r_to_cnt == TO_END);

    // Idle timer for a partial byte: restarts on any CNT edge and only runs mid-byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_cnt_edge || (r_rx_cnt == 3'd0) || w_rx_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_rx_timeout = 1'b0;
`endif

    // Shift SP in on each CNT rise (MSB first) and publish the byte on the 8th rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_shift <= '0;
            r_rx_cnt   <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_rx_edge) begin
                r_rx_shift <= {r_rx_shift[5:0], r_sp_s};
                r_rx_cnt   <= r_rx_cnt + 3'd1;
                if (r_rx_cnt == 3'd7) begin
                    r_rx_data  <= {r_rx_shift, r_sp_s};
                    r_rx_valid <= 1'b1;
                end
            end else if (w_rx_timeout) begin
                r_rx_shift <= '0;
                r_rx_cnt   <= '0;
            end
        end
    end

    // Transmit state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: each phase lasts CLK_DIV clk, the closing gap 2*CLK_DIV.
    always_comb begin
        w_tmr_done  = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_SETUP, S_LOW, S_HIGH: w_tmr_done = (r_tmr == HALF_END);
            S_GAP:                  w_tmr_done = (r_tmr == GAP_END);
            default:                w_tmr_done = 1'b0;
        endcase
        case (r_state)
            S_IDLE:  if (w_accept)   w_state_nxt = S_SETUP;
            S_SETUP: if (w_tmr_done) w_state_nxt = S_LOW;
            S_LOW:   if (w_tmr_done) w_state_nxt = S_HIGH;
            S_HIGH:  if (w_tmr_done) w_state_nxt = (r_bit == 3'd7) ? S_GAP : S_LOW;
            S_GAP:   if (w_tmr_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pin drive per state: CNT low only in LOW, SP carries the current bit through LOW and HIGH.
    always_comb begin
        w_cnt_oe  = 1'b0;
        w_cnt_out = 1'b1;
        w_sp_out  = 1'b1;
        case (r_state)
            S_SETUP: w_cnt_oe = 1'b1;
            S_LOW: begin
                w_cnt_oe  = 1'b1;
                w_cnt_out = 1'b0;
                w_sp_out  = r_tx_shift[7];
            end
            S_HIGH: begin
                w_cnt_oe = 1'b1;
                w_sp_out = r_tx_shift[7];
            end
            S_GAP:   w_cnt_oe = 1'b1;
            default: w_cnt_oe = 1'b0;
        endcase
    end

    // Phase timer, transmit shifter and bit counter; the bit shifts out at the end of HIGH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmr      <= '0;
            r_tx_shift <= '0;
            r_bit      <= '0;
            r_idle_q   <= 1'b0;
        end else begin
            r_idle_q <= (r_state == S_IDLE);
            if ((r_state == S_IDLE) || (w_state_nxt != r_state)) begin
                r_tmr <= '0;
            end else begin
                r_tmr <= r_tmr + 1'b1;
            end
            if (w_accept) begin
                r_tx_shift <= tx_data;
                r_bit      <= '0;
            end else if ((r_state == S_HIGH) && w_tmr_done) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                r_bit      <= r_bit + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdr_peer.sv
// tb_sdr_peer: drives sdr_peer from a behavioural CIA model on the SP/CNT pins and a local byte source.
// Latency: expected rx/tx bytes, pulse widths and handshake timings derive from the serial protocol rules.
// Backpressure: the local source holds tx_valid until tx_ready, with bounded waits everywhere.
module tb_sdr_peer;

    localparam int CLK_DIV = 16;
    localparam int RX_TO   = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       cnt_in, sp_in;
    logic       cnt_out, cnt_oe, sp_out;
    logic       cia_cnt, cia_sp;

    // Shared pins: whoever has the output enable drives them.
    assign cnt_in = cnt_oe ? cnt_out : cia_cnt;
    assign sp_in  = cnt_oe ? sp_out  : cia_sp;

    sdr_peer #(.CLK_DIV(CLK_DIV), .RX_TIMEOUT(RX_TO)) dut (
        .clk(clk), .reset(reset),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .cnt_in(cnt_in), .sp_in(sp_in),
        .cnt_out(cnt_out), .cnt_oe(cnt_oe), .sp_out(sp_out)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         rise_cyc = 0;
    int         t_acc = 0;
    bit         oe_seen = 1'b0;
    int         ob_bits = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // CIA in SP input mode: latches SP on each CNT rise, checks low-pulse width and the trailing gap.
    initial begin : cia_rx
        logic [7:0] ob_byte;
        int         ob_low;
        int         ob_last_rise;
        logic       ob_prev_cnt;
        logic       ob_prev_oe;
        ob_byte = 8'h00; ob_low = 0; ob_last_rise = 0; ob_prev_cnt = 1'b1; ob_prev_oe = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ob_bits = 0; ob_low = 0; ob_prev_cnt = 1'b1; ob_prev_oe = 1'b0;
            end else begin
                if (cnt_oe) oe_seen = 1'b1;
                if (cnt_oe && !cnt_out) ob_low++;
                if (cnt_oe && cnt_out && !ob_prev_cnt) begin
                    chk("cnt_low_width", ob_low, CLK_DIV);
                    ob_low = 0;
                    ob_byte = {ob_byte[6:0], sp_out};
                    ob_bits++;
                    ob_last_rise = cyc;
                    if (ob_bits == 8) begin
                        ob_bits = 0;
                        if (exp_tx.size() == 0) chk("tx_unexpected", int'(ob_byte), 256);
                        else chk("tx_byte", int'(ob_byte), int'(exp_tx.pop_front()));
                    end
                end
                // Last HIGH phase plus the 2*CLK_DIV gap before the pins are released.
                if (ob_prev_oe && !cnt_oe && ob_bits == 0)
                    chk("gap_tail", cyc - ob_last_rise, 3 * CLK_DIV);
                ob_prev_cnt = cnt_oe ? cnt_out : 1'b1;
                ob_prev_oe  = cnt_oe;
            end
        end
    end

    // Local receive side: every rx_valid must match the next byte the CIA shifted out, 3 clk after its 8th rise.
    initial forever begin
        @(negedge clk);
        if (!reset && rx_valid) begin
            chk("rx_latency", cyc - rise_cyc, 3);
            if (exp_rx.size() == 0) chk("rx_unexpected", int'(rx_data), 256);
            else chk("rx_byte", int'(rx_data), int'(exp_rx.pop_front()));
        end
    end

    // CIA in SP output mode: SP changes on the CNT fall, bits first..last of b, MSB first.
    task automatic cia_shift(input logic [7:0] b, input int first, input int last, input int half);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            cia_cnt = 1'b0;
            cia_sp  = b[7-i];
            repeat (half) @(negedge clk);
            cia_cnt  = 1'b1;
            rise_cyc = cyc;
            repeat (half - 1) @(negedge clk);
        end
        cia_sp = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        exp_tx.push_back(b);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_accept", int'(tx_ready), 1);
        if (tx_ready) begin
            t_acc = cyc;
            @(posedge clk);
            #1;
        end
        if (!hold || !tx_ready) begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        bit ok;
        n = 0; ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            ok = !busy && tx_ready && exp_tx.size() == 0 && exp_rx.size() == 0;
        end
        chk("quiet", int'(ok), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int         n;
        int         t1;
        bit         seen;
        logic [7:0] b;
        logic [7:0] b2;
        int         h;

        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; cia_cnt = 1'b1; cia_sp = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cnt_out", int'(cnt_out), 1);
        chk("rst_sp_out", int'(sp_out), 1);
        chk("rst_cnt_oe", int'(cnt_oe), 0);
        chk("rst_tx_ready", int'(tx_ready), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_tx_ready", int'(tx_ready), 1);
        chk("rel_cnt_oe", int'(cnt_oe), 0);

        // CIA sends A5 with timer A=2 (CNT half-period 12 clk); we must never drive the pins.
        oe_seen = 1'b0;
        exp_rx.push_back(8'hA5);
        cia_shift(8'hA5, 0, 3, 12);
        chk("rx_partial_busy", int'(busy), 1);
        cia_shift(8'hA5, 4, 7, 12);
        wait_quiet(200);
        chk("rx_no_oe", int'(oe_seen), 0);

        // Single transmit of 3C; tx_ready returns 19*CLK_DIV+1 clk after the accepting edge.
        send_byte(8'h3C, 1'b0);
        chk("tx_oe_on", int'(cnt_oe), 1);
        n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_return", cyc - t_acc - 1, 19 * CLK_DIV + 1);
        wait_quiet(100);

        // Back-to-back with tx_valid held: accepts are one byte time plus ready delay apart.
        send_byte(8'h01, 1'b1);
        t1 = t_acc;
        send_byte(8'h80, 1'b0);
        chk("b2b_spacing", t_acc - t1, 19 * CLK_DIV + 2);
        wait_quiet(1000);

        // Hold-off: 3 bits in flight, tx_valid must wait for the remaining 5.
        exp_rx.push_back(8'hC3);
        cia_shift(8'hC3, 0, 2, 10);
        exp_tx.push_back(8'hFF);
        tx_data = 8'hFF; tx_valid = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (tx_ready) seen = 1'b1;
        end
        chk("holdoff_ready", int'(seen), 0);
        cia_shift(8'hC3, 3, 7, 10);
        chk("holdoff_accepted", int'(cnt_oe), 1);
        tx_valid = 1'b0;
        wait_quiet(1000);

        // Randomised mix of receives, single sends after junk, and back-to-back pairs.
        for (int it = 0; it < 10; it++) begin
            b  = 8'($urandom);
            b2 = 8'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    h = $urandom_range(4, 20);
                    exp_rx.push_back(b);
                    cia_shift(b, 0, 7, h);
                    wait_quiet(400);
                end
                1: begin
                    tx_data = b2;
                    repeat ($urandom_range(1, 5)) @(negedge clk);
                    send_byte(b, 1'b0);
                    wait_quiet(800);
                end
                default: begin
                    send_byte(b, 1'b1);
                    send_byte(b2, 1'b0);
                    wait_quiet(1200);
                end
            endcase
        end

        // Reset in the middle of a transmit, after four bits have reached the CIA.
        send_byte(8'hB7, 1'b0);
        n = 0;
        while (ob_bits < 4 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("mid_bits", ob_bits, 4);
        #2 reset = 1'b1;
        #1;
        chk("mid_cnt_oe", int'(cnt_oe), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_cnt_out", int'(cnt_out), 1);
        exp_tx.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rel_ready", int'(tx_ready), 1);
        send_byte(8'h5A, 1'b0);
        wait_quiet(800);

`ifdef SDR_PEER_RX_TIMEOUT_EN
        // Partial byte is dropped after RX_TO idle clk, without an rx_valid.
        cia_shift(8'h6D, 0, 2, 10);
        repeat (RX_TO - 200) @(negedge clk);
        chk("to_busy_hold", int'(busy), 1);
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("to_busy_clear", int'(busy), 0);
        chk("to_ready", int'(tx_ready), 1);
`else
        // Without the timeout a partial byte persists until its remaining edges arrive.
        cia_shift(8'h6D, 0, 2, 10);
        repeat (5000) @(negedge clk);
        chk("persist_busy", int'(busy), 1);
        chk("persist_ready", int'(tx_ready), 0);
        exp_rx.push_back(8'h6D);
        cia_shift(8'h6D, 3, 7, 10);
        wait_quiet(200);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
